// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit for the MIPS core.
// A 32-step shift-add multiply or restoring divide runs while the datapath
// is stalled. The unit owns the architectural HI/LO registers.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // op[1] selects divide, op[0] selects signed
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               is_div;
    logic               is_signed;
    logic               div_by_zero;
    logic               last_iter;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               trial_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_neg;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_neg;
    logic [WIDTH-1:0]   rem_fix;

    assign is_div      = op_q[1];
    assign is_signed   = op_q[0];
    assign div_by_zero = is_div && (b_q == '0);
    assign last_iter   = (cnt == CW'(WIDTH - 1));

    // Operand magnitudes; the most negative value maps to 2^(W-1) as unsigned
    always_comb begin
        a_abs = a_q;
        b_abs = b_q;
        if (is_signed && a_q[WIDTH-1]) a_abs = -a_q;
        if (is_signed && b_q[WIDTH-1]) b_abs = -b_q;
    end

    // One multiply step: conditional add into the upper half (carry kept), then shift right
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // One restoring-divide step; the shifted remainder needs W+1 bits before the trial subtract
    always_comb begin
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        trial_ok = (rem_sh >= {1'b0, b_q});
        rem_diff = rem_sh - {1'b0, b_q};
        div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        if (trial_ok) div_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Sign correction of the unsigned result; the remainder follows the dividend sign
    always_comb begin
        prod_neg = -acc;
        quo_neg  = -acc[WIDTH-1:0];
        rem_neg  = -acc[2*WIDTH-1:WIDTH];
        prod_fix = acc;
        quo_fix  = acc[WIDTH-1:0];
        rem_fix  = acc[2*WIDTH-1:WIDTH];
        if (sign_a ^ sign_b) begin
            prod_fix = prod_neg;
            quo_fix  = quo_neg;
        end
        if (sign_a) rem_fix = rem_neg;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                stall = start;
                if (start) state_next = S_PREP;
            end
            S_PREP: begin
                busy  = 1'b1;
                stall = 1'b1;
                state_next = div_by_zero ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (last_iter) state_next = S_FIX;
            end
            S_FIX: begin
                busy  = 1'b1;
                stall = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO/div_zero registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        a_q      <= rs_data;
                        b_q      <= rt_data;
                        div_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    // The cleared upper half is the product/remainder; the lower
                    // half carries the multiplier or dividend that gets shifted out
                    sign_a <= is_signed & a_q[WIDTH-1];
                    sign_b <= is_signed & b_q[WIDTH-1];
                    a_q    <= a_abs;
                    b_q    <= b_abs;
                    cnt    <= '0;
                    acc    <= is_div ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                    if (div_by_zero) begin
                        div_zero <= 1'b1;
                        hi       <= a_q;
                        lo       <= '1;
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the MIPS processor. It executes MULT, MULTU, DIV and DIVU using a radix-2 shift-add / restoring-divide loop over 32 cycles. While it runs, it holds the single-cycle datapath with a stall, and it owns the architectural HI/LO registers. The ALU is not used by this block; the control unit decodes the instruction and raises `start` with the operand values.

## Interface
- `WIDTH`, 32, operand width; HI/LO are each `WIDTH` bits; iteration count = `WIDTH`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start`.
- `rs_data`  in  WIDTH  multiplicand / dividend.
- `rt_data`  in  WIDTH  multiplier / divisor.
- `stall`  out  1  holds the PC and register-file write (combinational).
- `busy`  out  1  high in PREP, RUN, FIX.
- `done`  out  1  one-cycle pulse; HI/LO are valid in this cycle.
- `div_zero`  out  1  sticky flag set by a DIV/DIVU with `rt_data`=0; cleared on the next accepted start.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - `start`=1 latches `op`, `rs_data`, `rt_data` and goes to PREP.
  - `stall` = `start`, so the issuing instruction is frozen in its own cycle.
- PREP:
  - For signed ops, latch the operand signs and take the absolute values (two's-complement negate if the MSB is set).
  - Clear the accumulator and iteration counter.
  - For a divide with divisor 0: set `div_zero`, set hi = rs_data and lo = all ones, then go directly to DONE.
  - Otherwise go to RUN.
- RUN, 32 cycles, counter 0..31; leave to FIX when the counter reaches 31.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of the 2W-bit accumulator (W+1-bit adder, carry kept). Then shift the whole accumulator right by 1.
  - Divide, restoring: shift {remainder, quotient} left by 1. Trial-subtract the divisor from the remainder. If the result is non-negative, keep it and set the quotient LSB to 1.
- FIX, one cycle:
  - Signed multiply: negate the 2W-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write hi = product[2W-1:W] or remainder, and lo = product[W-1:0] or quotient.
  - Go to DONE.
- DONE: `done`=1, `stall`=0 (the instruction retires); go to IDLE unconditionally.
- Arithmetic is modulo 2^W. DIV of 0x80000000 by 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- HI/LO hold their values outside of PREP (div-by-zero case) and FIX writes.
- `start` outside IDLE is ignored; there is no queueing.
- Reset (any state, including mid-RUN) forces:
  - state IDLE;
  - hi = lo = 0;
  - `div_zero`=0, `done`=0, `busy`=0, `stall`=0;
  - counter 0.
  - An in-flight operation is discarded.

## Timing
- `start` is sampled at edge T, with the state in IDLE.
- Normal operation:
  - PREP in cycle T+1.
  - RUN in cycles T+2..T+33.
  - FIX in cycle T+34.
  - DONE in cycle T+35: `done`=1 and HI/LO are updated and visible.
  - IDLE in cycle T+36; this is the earliest next `start`.
- Latency is 35 cycles from the start cycle to the done cycle; the minimum start-to-start interval is 36 cycles.
- Divide by zero:
  - PREP in cycle T+1, with HI/LO and `div_zero` registered at the end of that cycle.
  - DONE in cycle T+2.
  - IDLE in cycle T+3.
- `stall` timing:
  - `stall` is high in the start cycle and in every PREP, RUN and FIX cycle.
  - `stall` is low in DONE and in idle cycles without `start`.
- `busy` is registered state decode; `done` is state decode of DONE.
- `hi`, `lo` and `div_zero` are direct register outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `done` at T+35, hi=0xFFFFFFFE, lo=0x00000001, `stall` high T..T+34.
- MULT −3 (0xFFFFFFFD) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2; DIV 0x80000000 / −1 -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> `done` at T+2, `div_zero`=1, hi=0x1234, lo=0xFFFFFFFF; the next MULTU start clears `div_zero`.
- `start` pulsed at T+10 and at T+35 (DONE) during a running MULTU -> both ignored, a single `done`, result unchanged; a start at T+36 is accepted.
- `reset` low at T+20 of a DIV -> immediately IDLE, hi=lo=0, `busy`=`stall`=`done`=0; after release, a fresh MULTU 6×7 gives lo=42, hi=0.
